regfile_sc: RTL

- General-purpose register file that answers the ID stage's two read requests (read-enable plus address per port) and accepts the single write-back port from the WB stage.
- 32 x 32-bit registers; r0 reads as zero at all times.
- After reset, a built-in clear sequencer zeroes the array one register per cycle and holds busy_o high until the array is clean.
- Optional same-cycle write-through bypass, so ID sees a value written back in the same cycle.

---
 rtl/regfile_sc.sv | 67 ++++++
 1 files changed

// File: rtl/regfile_sc.sv
// regfile_sc: 32x32 register file, two combinational reads, one write, post-reset clear sequencer (optional bypass: REGFILE_BYPASS_EN).
module regfile_sc #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic              busy_o
);
  typedef enum logic {CLEAR, READY} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] clr_ptr, clr_ptr_n;
  logic busy_n;
  logic [DATA_W-1:0] mem [NUM_REGS];
  logic last;
  logic byp1, byp2;
  assign last = clr_ptr == ADDR_W'(NUM_REGS - 1);
  always_comb begin
    state_n = state;
    clr_ptr_n = clr_ptr;
    busy_n = busy_o;
    if (state == CLEAR) begin
      clr_ptr_n = clr_ptr + ADDR_W'(1);
      state_n = last ? READY : CLEAR;
      busy_n = !last;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      clr_ptr <= ADDR_W'(1);
      busy_o <= 1'b1;
    end else begin
      state <= state_n;
      clr_ptr <= clr_ptr_n;
      busy_o <= busy_n;
    end
  end
  // r0 is never written by the sequencer nor the write port; reads of it are forced to zero
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) mem[clr_ptr] <= '0;
      else if (we && waddr != '0) mem[waddr] <= wdata;
    end
  end
`ifdef REGFILE_BYPASS_EN
  assign byp1 = we && waddr == raddr1;
  assign byp2 = we && waddr == raddr2;
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif
  always_comb begin
    rdata1 = (rst || busy_o || !re1 || raddr1 == '0) ? '0 : byp1 ? wdata : mem[raddr1];
    rdata2 = (rst || busy_o || !re2 || raddr2 == '0) ? '0 : byp2 ? wdata : mem[raddr2];
  end
endmodule
